// File: rtl/rabbit_pkg.sv
// Shared types and constants for the Rabbit counter-system engine.
package rabbit_pkg;

    // Engine control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WORD_W  = 32;
    localparam int DEF_NUM_CTR = 8;

    // Rabbit counter constants A_0..A_7; word i sits at [i*32 +: 32]
    localparam logic [DEF_NUM_CTR*DEF_WORD_W-1:0] DEF_A_VEC = {
        32'hD34D34D3, 32'h4D34D34D, 32'h34D34D34, 32'hD34D34D3,
        32'h4D34D34D, 32'h34D34D34, 32'hD34D34D3, 32'h4D34D34D
    };

    // Segment that owns counter word idx when the chain is cut into lanes-wide slices
    function automatic int seg_of(input int idx, input int lanes);
        return idx / lanes;
    endfunction

endpackage

// File: rtl/rabbit_counter_engine_if.sv
// Load / step / result handshake bundle between the engine and its neighbours.
interface rabbit_counter_engine_if #(
    parameter int WORD_W  = 32,
    parameter int NUM_CTR = 8,
    parameter int ITER_W  = 16
);
    logic                        load;
    logic                        load_ready;
    logic [NUM_CTR*WORD_W-1:0]   load_ctr;
    logic                        load_carry;
    logic                        step_valid;
    logic                        step_ready;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_CTR*WORD_W-1:0]   counter_out;
    logic                        carry_out;
    logic [ITER_W-1:0]           iter_cnt;
    logic                        busy;

    modport master (
        output load, load_ctr, load_carry, step_valid, out_ready,
        input  load_ready, step_ready, out_valid, counter_out, carry_out, iter_cnt, busy
    );

    modport slave (
        input  load, load_ctr, load_carry, step_valid, out_ready,
        output load_ready, step_ready, out_valid, counter_out, carry_out, iter_cnt, busy
    );
endinterface

// File: rtl/rabbit_ctr_lane.sv
// One word of the Rabbit counter carry chain: C + A + b, WORD_W+1 bits wide.
module rabbit_ctr_lane #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] c_i,
    input  logic [WORD_W-1:0] a_i,
    input  logic              b_i,
    output logic [WORD_W-1:0] c_next_o,
    output logic              b_o
);
    logic [WORD_W:0] sum_s;

    assign sum_s    = {1'b0, c_i} + {1'b0, a_i} + {{WORD_W{1'b0}}, b_i};
    assign c_next_o = sum_s[WORD_W-1:0];
    assign b_o      = sum_s[WORD_W];
endmodule

// File: rtl/rabbit_counter_engine.sv
// Rabbit counter-system engine: holds counter state and carry, and advances them
// by one counter iteration per accepted step, LANES words per clock.
module rabbit_counter_engine
    import rabbit_pkg::*;
#(
    parameter int                               WORD_W  = 32,
    parameter int                               NUM_CTR = 8,
    parameter int                               LANES   = 8,
    parameter logic [NUM_CTR*WORD_W-1:0]        A_VEC   = DEF_A_VEC,
    parameter int                               ITER_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rabbit_counter_engine_if.slave bus
);
    localparam int CW       = NUM_CTR * WORD_W;
    localparam int S        = NUM_CTR / LANES;
    localparam int SEG_W    = (S > 1) ? $clog2(S) : 1;
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(S - 1);

    state_e             state_q;
    logic [SEG_W-1:0]   seg_q;
    logic [CW-1:0]      ctr_q;
    logic [CW-1:0]      ctr_d;
    logic               carry_q;
    logic               carry_d;
    logic [ITER_W-1:0]  iter_q;
    logic               load_ready_q;
    logic               busy_q;
    logic               out_valid_q;

    logic [WORD_W-1:0]  lane_c_s [LANES];
    logic [WORD_W-1:0]  lane_a_s [LANES];
    logic [WORD_W-1:0]  lane_n_s [LANES];

    // Route the active segment's counter words and constants onto the lanes
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_c_s[l] = ctr_q[(int'(seg_q) * LANES + l) * WORD_W +: WORD_W];
            lane_a_s[l] = A_VEC[(int'(seg_q) * LANES + l) * WORD_W +: WORD_W];
        end
    end

    // Lanes chained in ascending word order; lane 0 takes the carry register
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic b_in_s;
        logic b_out_s;
        if (l == 0) begin : g_first
            assign b_in_s = carry_q;
        end else begin : g_next
            assign b_in_s = g_lane[l-1].b_out_s;
        end
        rabbit_ctr_lane #(.WORD_W(WORD_W)) u_lane (
            .c_i      (lane_c_s[l]),
            .a_i      (lane_a_s[l]),
            .b_i      (b_in_s),
            .c_next_o (lane_n_s[l]),
            .b_o      (b_out_s)
        );
    end

    assign carry_d = g_lane[LANES-1].b_out_s;

    // Next counter image: only words of the active segment take lane results
    always_comb begin
        ctr_d = ctr_q;
        for (int i = 0; i < NUM_CTR; i++) begin
            if (seg_of(i, LANES) == int'(seg_q)) begin
                ctr_d[i*WORD_W +: WORD_W] = lane_n_s[i % LANES];
            end else begin
                ctr_d[i*WORD_W +: WORD_W] = ctr_q[i*WORD_W +: WORD_W];
            end
        end
    end

    // Control FSM with registered status flags and the counter/carry/iteration state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            seg_q        <= {SEG_W{1'b0}};
            ctr_q        <= {CW{1'b0}};
            carry_q      <= 1'b0;
            iter_q       <= {ITER_W{1'b0}};
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        // Load has priority; a concurrent step waits a cycle
                        ctr_q   <= bus.load_ctr;
                        carry_q <= bus.load_carry;
                        iter_q  <= {ITER_W{1'b0}};
                    end else if (bus.step_valid) begin
                        state_q      <= RUN;
                        seg_q        <= {SEG_W{1'b0}};
                        load_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    ctr_q   <= ctr_d;
                    carry_q <= carry_d;
                    if (seg_q == SEG_LAST) begin
                        state_q     <= DONE;
                        seg_q       <= {SEG_W{1'b0}};
                        iter_q      <= iter_q + {{(ITER_W-1){1'b0}}, 1'b1};
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        seg_q <= seg_q + {{(SEG_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q      <= IDLE;
                        out_valid_q  <= 1'b0;
                        load_ready_q <= 1'b1;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    seg_q        <= {SEG_W{1'b0}};
                    load_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    out_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.load_ready  = load_ready_q;
    assign bus.step_ready  = load_ready_q && !bus.load;
    assign bus.out_valid   = out_valid_q;
    assign bus.counter_out = ctr_q;
    assign bus.carry_out   = carry_q;
    assign bus.iter_cnt    = iter_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_rabbit_counter_engine.sv
// Directed bench for rabbit_counter_engine: three instances cover S=1, S=4 and a 2-bit iteration counter.
module tb_rabbit_counter_engine;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int CW = N * W;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          load_s       [ND];
    logic [CW-1:0] load_ctr_s   [ND];
    logic          load_carry_s [ND];
    logic          step_s       [ND];
    logic          ordy_s       [ND];
    logic [CW-1:0] ctr_w        [ND];
    logic          carry_w      [ND];
    logic          ov_w         [ND];
    logic          lr_w         [ND];
    logic          sr_w         [ND];
    logic          busy_w       [ND];
    logic [15:0]   iter_w       [ND];

    int n_assert = 0;
    int n_fail   = 0;
    logic [CW-1:0] a_exp;
    logic [CW-1:0] exp_v;

    rabbit_counter_engine_if #(.WORD_W(W), .NUM_CTR(N), .ITER_W(16)) if0 ();
    rabbit_counter_engine_if #(.WORD_W(W), .NUM_CTR(N), .ITER_W(16)) if1 ();
    rabbit_counter_engine_if #(.WORD_W(W), .NUM_CTR(N), .ITER_W(2))  if2 ();

    rabbit_counter_engine #(.WORD_W(W), .NUM_CTR(N), .LANES(8), .ITER_W(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    rabbit_counter_engine #(.WORD_W(W), .NUM_CTR(N), .LANES(2), .ITER_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    rabbit_counter_engine #(.WORD_W(W), .NUM_CTR(N), .LANES(8), .ITER_W(2))  dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.load = load_s[0];  assign if0.load_ctr = load_ctr_s[0];  assign if0.load_carry = load_carry_s[0];
    assign if0.step_valid = step_s[0];  assign if0.out_ready = ordy_s[0];
    assign ctr_w[0] = if0.counter_out;  assign carry_w[0] = if0.carry_out;  assign ov_w[0] = if0.out_valid;
    assign lr_w[0] = if0.load_ready;  assign sr_w[0] = if0.step_ready;  assign busy_w[0] = if0.busy;
    assign iter_w[0] = if0.iter_cnt;

    assign if1.load = load_s[1];  assign if1.load_ctr = load_ctr_s[1];  assign if1.load_carry = load_carry_s[1];
    assign if1.step_valid = step_s[1];  assign if1.out_ready = ordy_s[1];
    assign ctr_w[1] = if1.counter_out;  assign carry_w[1] = if1.carry_out;  assign ov_w[1] = if1.out_valid;
    assign lr_w[1] = if1.load_ready;  assign sr_w[1] = if1.step_ready;  assign busy_w[1] = if1.busy;
    assign iter_w[1] = if1.iter_cnt;

    assign if2.load = load_s[2];  assign if2.load_ctr = load_ctr_s[2];  assign if2.load_carry = load_carry_s[2];
    assign if2.step_valid = step_s[2];  assign if2.out_ready = ordy_s[2];
    assign ctr_w[2] = if2.counter_out;  assign carry_w[2] = if2.carry_out;  assign ov_w[2] = if2.out_valid;
    assign lr_w[2] = if2.load_ready;  assign sr_w[2] = if2.step_ready;  assign busy_w[2] = if2.busy;
    assign iter_w[2] = {14'd0, if2.iter_cnt};

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input int d, input logic [CW-1:0] v, input logic c);
        load_s[d]       = 1'b1;
        load_ctr_s[d]   = v;
        load_carry_s[d] = c;
        tick();
        load_s[d]       = 1'b0;
    endtask

    // Request one step, wait for out_valid, check cycles from acceptance; leaves DUT in DONE
    task automatic do_step(input int d, input int lat);
        int cnt = 0;
        step_s[d] = 1'b1;
        tick();
        step_s[d] = 1'b0;
        while (ov_w[d] !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        check($sformatf("latency_d%0d", d), CW'(cnt), CW'(lat));
    endtask

    task automatic ack(input int d);
        ordy_s[d] = 1'b1;
        tick();
        ordy_s[d] = 1'b0;
        check($sformatf("ack_idle_d%0d", d), CW'(lr_w[d]), CW'(1'b1));
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < ND; i++) begin
            load_s[i] = 1'b0; load_ctr_s[i] = '0; load_carry_s[i] = 1'b0;
            step_s[i] = 1'b0; ordy_s[i] = 1'b0;
        end
        a_exp = {32'hD34D34D3, 32'h4D34D34D, 32'h34D34D34, 32'hD34D34D3,
                 32'h4D34D34D, 32'h34D34D34, 32'hD34D34D3, 32'h4D34D34D};

        // Reset state
        rst = 1'b1;
        tick(); tick();
        check("rst_ctr",   ctr_w[0], '0);
        check("rst_carry", CW'(carry_w[0]), CW'(1'b0));
        check("rst_iter",  CW'(iter_w[0]), CW'(16'd0));
        check("rst_ov",    CW'(ov_w[0]), CW'(1'b0));
        check("rst_busy",  CW'(busy_w[0]), CW'(1'b0));
        check("rst_lr",    CW'(lr_w[0]), CW'(1'b1));
        check("rst_sr",    CW'(sr_w[1]), CW'(1'b1));
        rst = 1'b0;
        tick();

        // Zeros + one step, S=1
        do_load(0, '0, 1'b0);
        do_step(0, 1);
        check("t1_ctr",   ctr_w[0], a_exp);
        check("t1_carry", CW'(carry_w[0]), CW'(1'b0));
        check("t1_iter",  CW'(iter_w[0]), CW'(16'd1));
        // DONE held with out_ready low
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_ov",  CW'(ov_w[0]), CW'(1'b1));
            check("hold_ctr", ctr_w[0], a_exp);
        end
        ack(0);

        // Carry ripple across segments, S=4
        exp_v = a_exp;
        exp_v[0 +: W] = 32'h4D34D34C;
        exp_v[W +: W] = 32'hD34D34D4;
        do_load(1, {{(CW-W){1'b0}}, 32'hFFFFFFFF}, 1'b0);
        do_step(1, 4);
        check("t2_ctr",   ctr_w[1], exp_v);
        check("t2_carry", CW'(carry_w[1]), CW'(1'b0));
        ack(1);

        // Final carry out of word 7, then it feeds word 0 of the next step
        exp_v = a_exp;
        exp_v[7*W +: W] = 32'h0;
        do_load(0, {32'h2CB2CB2D, {(CW-W){1'b0}}}, 1'b0);
        do_step(0, 1);
        check("t3_ctr",   ctr_w[0], exp_v);
        check("t3_carry", CW'(carry_w[0]), CW'(1'b1));
        ack(0);
        do_step(0, 1);
        check("t3_second_w0", CW'(ctr_w[0][W-1:0]), CW'(32'h9A69A69B));
        ack(0);

        // Loaded carry of 1 enters word 0
        do_load(0, '0, 1'b1);
        do_step(0, 1);
        check("cin_w0", CW'(ctr_w[0][W-1:0]), CW'(32'h4D34D34E));
        ack(0);

        // Load and step together in IDLE
        load_s[0] = 1'b1; load_ctr_s[0] = '0; load_carry_s[0] = 1'b0; step_s[0] = 1'b1;
        #1;
        check("cont_sr", CW'(sr_w[0]), CW'(1'b0));
        tick();
        load_s[0] = 1'b0;
        check("cont_ctr",  ctr_w[0], '0);
        check("cont_iter", CW'(iter_w[0]), CW'(16'd0));
        check("cont_busy0", CW'(busy_w[0]), CW'(1'b0));
        tick();
        step_s[0] = 1'b0;
        check("cont_busy1", CW'(busy_w[0]), CW'(1'b1));
        tick();
        check("cont_ov",  CW'(ov_w[0]), CW'(1'b1));
        check("cont_res", ctr_w[0], a_exp);
        ack(0);

        // Load during RUN/DONE is ignored
        do_load(1, '0, 1'b0);
        step_s[1] = 1'b1;
        tick();
        step_s[1] = 1'b0;
        load_s[1] = 1'b1; load_ctr_s[1] = '1; load_carry_s[1] = 1'b1;
        #1;
        check("runld_lr",   CW'(lr_w[1]), CW'(1'b0));
        check("runld_busy", CW'(busy_w[1]), CW'(1'b1));
        cnt = 0;
        while (ov_w[1] !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        load_s[1] = 1'b0;
        check("runld_ctr",   ctr_w[1], a_exp);
        check("runld_carry", CW'(carry_w[1]), CW'(1'b0));
        check("runld_iter",  CW'(iter_w[1]), CW'(16'd1));
        ack(1);

        // 2-bit iteration counter wraps
        do_load(2, '0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            do_step(2, 1);
            check("wrap_iter", CW'(iter_w[2]), CW'(k % 4));
            ack(2);
        end

        // Reset in the middle of RUN, at segment 2
        do_load(1, '0, 1'b0);
        step_s[1] = 1'b1;
        tick();
        step_s[1] = 1'b0;
        tick(); tick();
        exp_v = '0;
        exp_v[0 +: 4*W] = a_exp[0 +: 4*W];
        check("mid_partial", ctr_w[1], exp_v);
        rst = 1'b1;
        #1;
        check("mid_rst_ctr",   ctr_w[1], '0);
        check("mid_rst_carry", CW'(carry_w[1]), CW'(1'b0));
        check("mid_rst_busy",  CW'(busy_w[1]), CW'(1'b0));
        check("mid_rst_ov",    CW'(ov_w[1]), CW'(1'b0));
        check("mid_rst_lr",    CW'(lr_w[1]), CW'(1'b1));
        check("mid_rst_iter0", CW'(iter_w[0]), CW'(16'd0));
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", CW'(busy_w[1]), CW'(1'b0));
        exp_v = a_exp;
        exp_v[0 +: W] = 32'h4D34D34C;
        exp_v[W +: W] = 32'hD34D34D4;
        do_load(1, {{(CW-W){1'b0}}, 32'hFFFFFFFF}, 1'b0);
        do_step(1, 4);
        check("post_rst_ctr",  ctr_w[1], exp_v);
        check("post_rst_iter", CW'(iter_w[1]), CW'(16'd1));
        ack(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
